// File: rtl/sbn_loader_if.sv
// sbn_loader_if: byte stream input plus instruction/data memory write ports
// of the SBN program loader.
//
// Handshake: a byte on in_data is transferred on a rising clk edge where
// in_valid and in_ready are both 1. The source holds in_data stable while
// in_valid is high and the byte has not yet been taken. in_ready does not
// depend on in_valid.
interface sbn_loader_if #(
    parameter int FWIDTH = 8,
    parameter int DWIDTH = 32,
    parameter int IWIDTH = 4 * FWIDTH
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              im_we;
    logic [FWIDTH-1:0] im_addr;
    logic [IWIDTH-1:0] im_wdata;
    logic              dm_we;
    logic [FWIDTH-1:0] dm_addr;
    logic [DWIDTH-1:0] dm_wdata;

    // Stream source side, which also observes the memory write ports.
    modport master (
        output in_data, in_valid,
        input  in_ready, im_we, im_addr, im_wdata, dm_we, dm_addr, dm_wdata
    );

    // Loader side.
    modport slave (
        input  in_data, in_valid,
        output in_ready, im_we, im_addr, im_wdata, dm_we, dm_addr, dm_wdata
    );
endinterface

// File: rtl/sbn_loader.sv
// sbn_loader: parses CMD/ADDR/CNT/words frames from a byte stream, writes
// instruction and data words into the SBN memories and releases the machine
// (run) on a RUN command. Define SBN_LOADER_CKSUM_EN to require a trailing
// 8-bit modulo-sum checksum byte on every frame.
module sbn_loader #(
    parameter int FWIDTH = 8,
    parameter int DWIDTH = 32,
    parameter int IWIDTH = 4 * FWIDTH
) (
    input  logic       clk,
    input  logic       rst,
    sbn_loader_if.slave bus,
    output logic       run,
    output logic       err,
    output logic [2:0] fsm_state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_CNT   = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
`ifdef SBN_LOADER_CKSUM_EN
        S_RUN   = 3'd5,
        S_CKSUM = 3'd6
`else
        S_RUN   = 3'd5
`endif
    } state_t;

    localparam int WMAX = (IWIDTH > DWIDTH) ? IWIDTH : DWIDTH;
    localparam logic [7:0] I_LAST = 8'(IWIDTH / 8 - 1);
    localparam logic [7:0] D_LAST = 8'(DWIDTH / 8 - 1);

    state_t            state, next_state;
    logic              acc;
    logic              err_set;
    logic              is_im;
    logic [FWIDTH-1:0] ptr;
    logic [8:0]        cnt;        // 9 bits so CNT=0 can hold 256
    logic [7:0]        byte_idx;
    logic              last_byte;
    logic [WMAX-1:0]   sh;
    logic [WMAX-1:0]   word_next;
`ifdef SBN_LOADER_CKSUM_EN
    logic [7:0]        sum;
    logic              run_frame;
`endif

    assign acc          = bus.in_valid && bus.in_ready;
    assign bus.in_ready = !rst && (state != S_WRITE);
    assign last_byte    = (byte_idx == (is_im ? I_LAST : D_LAST));
    assign word_next    = (sh << 8) | WMAX'(bus.in_data);
    assign fsm_state    = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state decode and protocol error detection.
    always_comb begin
        next_state = state;
        err_set    = 1'b0;
        case (state)
            S_IDLE: if (acc) begin
                case (bus.in_data)
                    8'h01, 8'h02: next_state = S_ADDR;
`ifdef SBN_LOADER_CKSUM_EN
                    8'h03:        next_state = S_CKSUM;
`else
                    8'h03:        next_state = S_RUN;
`endif
                    default:      err_set = 1'b1;
                endcase
            end
            S_ADDR:  if (acc) next_state = S_CNT;
            S_CNT:   if (acc) next_state = S_DATA;
            S_DATA:  if (acc && last_byte) next_state = S_WRITE;
            S_WRITE: begin
                if (cnt == 9'd1) begin
`ifdef SBN_LOADER_CKSUM_EN
                    next_state = S_CKSUM;
`else
                    next_state = S_IDLE;
`endif
                end else begin
                    next_state = S_DATA;
                end
            end
            S_RUN:   if (acc && bus.in_data == 8'hFF) next_state = S_IDLE;
`ifdef SBN_LOADER_CKSUM_EN
            S_CKSUM: if (acc) begin
                if (bus.in_data != sum) begin
                    err_set    = 1'b1;
                    next_state = S_IDLE;
                end else begin
                    next_state = run_frame ? S_RUN : S_IDLE;
                end
            end
`endif
            default: next_state = S_IDLE;
        endcase
    end

    // Frame datapath: pointer/count, word assembly, write strobes, run/err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_im    <= 1'b0;
            ptr      <= '0;
            cnt      <= '0;
            byte_idx <= '0;
            sh       <= '0;
            bus.im_we    <= 1'b0;
            bus.im_addr  <= '0;
            bus.im_wdata <= '0;
            bus.dm_we    <= 1'b0;
            bus.dm_addr  <= '0;
            bus.dm_wdata <= '0;
            run      <= 1'b0;
            err      <= 1'b0;
        end else begin
            bus.im_we <= 1'b0;
            bus.dm_we <= 1'b0;
            if (acc) begin
                case (state)
                    S_IDLE: is_im <= (bus.in_data == 8'h01);
                    S_ADDR: ptr <= bus.in_data[FWIDTH-1:0];
                    S_CNT: begin
                        cnt      <= (bus.in_data == 8'h00) ? 9'd256 : {1'b0, bus.in_data};
                        byte_idx <= '0;
                    end
                    S_DATA: begin
                        sh <= word_next;
                        if (last_byte) begin
                            byte_idx <= '0;
                            if (is_im) begin
                                bus.im_we    <= 1'b1;
                                bus.im_addr  <= ptr;
                                bus.im_wdata <= word_next[IWIDTH-1:0];
                            end else begin
                                bus.dm_we    <= 1'b1;
                                bus.dm_addr  <= ptr;
                                bus.dm_wdata <= word_next[DWIDTH-1:0];
                            end
                        end else begin
                            byte_idx <= byte_idx + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
            if (state == S_WRITE) begin
                ptr <= ptr + 1'b1;     // wraps modulo 2^FWIDTH
                cnt <= cnt - 9'd1;
            end
            run <= (next_state == S_RUN);
            err <= err | err_set;
        end
    end

`ifdef SBN_LOADER_CKSUM_EN
    // Running checksum of the current frame, restarted by each CMD byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum       <= '0;
            run_frame <= 1'b0;
        end else if (acc) begin
            if (state == S_IDLE) begin
                sum       <= bus.in_data;
                run_frame <= (bus.in_data == 8'h03);
            end else begin
                sum <= sum + bus.in_data;
            end
        end
    end
`endif
endmodule

// File: tb/tb_sbn_loader.sv
// tb_sbn_loader: directed bench for sbn_loader (FWIDTH=8, DWIDTH=32).
// Covers the default build, or the checksum build when SBN_LOADER_CKSUM_EN
// is defined.
`define CHK(tag, obs, exp) \
    begin \
        total++; \
        assert ((obs) === (exp)) else begin \
            bad++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

module tb_sbn_loader;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd5;
    localparam logic [2:0] ST_CKSUM = 3'd6;

    logic       clk;
    logic       rst;
    logic       run;
    logic       err;
    logic [2:0] fsm_state;
    int         total = 0;
    int         bad   = 0;
    int         im_pulses = 0;
    int         dm_pulses = 0;
    int         both_pulses = 0;
    int         dm_base;

    sbn_loader_if #(.FWIDTH(8), .DWIDTH(32), .IWIDTH(32)) bus ();

    sbn_loader #(.FWIDTH(8), .DWIDTH(32), .IWIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .run       (run),
        .err       (err),
        .fsm_state (fsm_state)
    );

    // clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // strobe monitor
    always @(negedge clk) begin
        if (bus.im_we) im_pulses++;
        if (bus.dm_we) dm_pulses++;
        if (bus.im_we && bus.dm_we) both_pulses++;
    end

    // driver: present one byte and return 1 time unit after the accepting edge
    task automatic send(input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            total++;
            bad++;
            $error("FAIL ready_wait observed=0 expected=1");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[31:24]);
        send(w[23:16]);
        send(w[15:8]);
        send(w[7:0]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #12;
        `CHK("rst_ready", bus.in_ready, 1'b0)
        `CHK("rst_state", fsm_state, ST_IDLE)
        `CHK("rst_run", run, 1'b0)
        `CHK("rst_err", err, 1'b0)
        `CHK("rst_im_we", bus.im_we, 1'b0)
        `CHK("rst_dm_we", bus.dm_we, 1'b0)
        `CHK("rst_im_addr", bus.im_addr, 8'h00)
        `CHK("rst_dm_wdata", bus.dm_wdata, 32'h0)
        @(negedge clk);
        rst = 1'b0;
        #1;
        `CHK("post_rst_ready", bus.in_ready, 1'b1)

`ifndef SBN_LOADER_CKSUM_EN
        // instruction load, two words
        send(8'h01); send(8'h10); send(8'h02);
        send_word(32'hAABBCCDD);
        `CHK("im0_we", bus.im_we, 1'b1)
        `CHK("im0_addr", bus.im_addr, 8'h10)
        `CHK("im0_data", bus.im_wdata, 32'hAABBCCDD)
        `CHK("im0_ready", bus.in_ready, 1'b0)
        `CHK("im0_dm_we", bus.dm_we, 1'b0)
        send_word(32'h11223344);
        `CHK("im1_we", bus.im_we, 1'b1)
        `CHK("im1_addr", bus.im_addr, 8'h11)
        `CHK("im1_data", bus.im_wdata, 32'h11223344)
        `CHK("im1_ready", bus.in_ready, 1'b0)
        step();
        `CHK("im_end_state", fsm_state, ST_IDLE)
        `CHK("im_end_we", bus.im_we, 1'b0)
        `CHK("im_hold_addr", bus.im_addr, 8'h11)
        `CHK("im_hold_data", bus.im_wdata, 32'h11223344)
        `CHK("im_pulses", im_pulses, 2)
        `CHK("im_no_dm", dm_pulses, 0)

        // data load across the address wrap
        send(8'h02); send(8'hFF); send(8'h02);
        send_word(32'h00000005);
        `CHK("dmw0_we", bus.dm_we, 1'b1)
        `CHK("dmw0_addr", bus.dm_addr, 8'hFF)
        `CHK("dmw0_data", bus.dm_wdata, 32'h00000005)
        send_word(32'hFFFFFFFF);
        `CHK("dmw1_we", bus.dm_we, 1'b1)
        `CHK("dmw1_addr", bus.dm_addr, 8'h00)
        `CHK("dmw1_data", bus.dm_wdata, 32'hFFFFFFFF)
        `CHK("dmw1_err", err, 1'b0)
        step();
        `CHK("dmw_pulses", dm_pulses, 2)

        // RUN, ignored byte, stop
        send(8'h03);
        `CHK("run_on", run, 1'b1)
        `CHK("run_state", fsm_state, ST_RUN)
        send(8'h55);
        `CHK("run_ignore", run, 1'b1)
        send(8'hFF);
        `CHK("run_off", run, 1'b0)
        `CHK("run_off_state", fsm_state, ST_IDLE)

        // bad command, then a valid frame still loads
        send(8'h07);
        `CHK("bad_err", err, 1'b1)
        `CHK("bad_state", fsm_state, ST_IDLE)
        step();
        `CHK("bad_no_im", im_pulses, 2)
        `CHK("bad_no_dm", dm_pulses, 2)
        send(8'h02); send(8'h00); send(8'h01);
        send_word(32'h00000009);
        `CHK("after_bad_we", bus.dm_we, 1'b1)
        `CHK("after_bad_addr", bus.dm_addr, 8'h00)
        `CHK("after_bad_data", bus.dm_wdata, 32'h00000009)
        `CHK("after_bad_err", err, 1'b1)

        // asynchronous reset in the middle of a word
        send(8'h01); send(8'h20); send(8'h01); send(8'hAA); send(8'hBB);
        `CHK("mid_state", fsm_state, ST_DATA)
        #2;
        rst = 1'b1;
        #1;
        `CHK("arst_state", fsm_state, ST_IDLE)
        `CHK("arst_ready", bus.in_ready, 1'b0)
        `CHK("arst_err", err, 1'b0)
        `CHK("arst_im_addr", bus.im_addr, 8'h00)
        `CHK("arst_im_data", bus.im_wdata, 32'h0)
        `CHK("arst_dm_data", bus.dm_wdata, 32'h0)
        @(negedge clk);
        rst = 1'b0;
        send(8'h02); send(8'h05); send(8'h01);
        send_word(32'h00000007);
        `CHK("post_arst_we", bus.dm_we, 1'b1)
        `CHK("post_arst_addr", bus.dm_addr, 8'h05)
        `CHK("post_arst_data", bus.dm_wdata, 32'h00000007)
        step();

        // CNT=0 loads 256 words
        dm_base = dm_pulses;
        send(8'h02); send(8'h00); send(8'h00);
        for (int i = 0; i < 256; i++) send_word(32'(i) ^ 32'hA5000000);
        `CHK("c256_addr", bus.dm_addr, 8'hFF)
        `CHK("c256_data", bus.dm_wdata, 32'hA50000FF)
        step();
        `CHK("c256_state", fsm_state, ST_IDLE)
        `CHK("c256_pulses", dm_pulses - dm_base, 256)
`else
        // load frame with correct checksum 02+00+01+09 = 0C
        send(8'h02); send(8'h00); send(8'h01);
        send_word(32'h00000009);
        `CHK("ck_we", bus.dm_we, 1'b1)
        `CHK("ck_addr", bus.dm_addr, 8'h00)
        `CHK("ck_data", bus.dm_wdata, 32'h00000009)
        step();
        `CHK("ck_state", fsm_state, ST_CKSUM)
        send(8'h0C);
        `CHK("ck_ok_err", err, 1'b0)
        `CHK("ck_ok_state", fsm_state, ST_IDLE)

        // RUN with good checksum
        send(8'h03);
        `CHK("ck_run_wait", run, 1'b0)
        send(8'h03);
        `CHK("ck_run_on", run, 1'b1)
        `CHK("ck_run_state", fsm_state, ST_RUN)
        send(8'hFF);
        `CHK("ck_run_off", run, 1'b0)

        // RUN with bad checksum
        send(8'h03); send(8'h04);
        `CHK("ck_bad_err", err, 1'b1)
        `CHK("ck_bad_run", run, 1'b0)
        `CHK("ck_bad_state", fsm_state, ST_IDLE)
        step();
        `CHK("ck_pulses", dm_pulses, 1)
        `CHK("ck_no_im", im_pulses, 0)
`endif
        `CHK("never_both", both_pulses, 0)

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
